mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning edges from the multiplier start cycle until mul_result is valid.
REQ-002 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports req_valid in 1 / req_ready out 1  EX-stage request handshake.
REQ-006 SHALL have ports req_funct3 in 3 / req_a in XLEN / req_b in XLEN / req_rd in 5  operation, operands, destination tag.
REQ-007 SHALL have port flush  in  1  pipeline kill; discards the in-flight or pending operation.
REQ-008 SHALL have ports mul_start out 1 / mul_funct3 out 3 / mul_a out XLEN / mul_b out XLEN  drive to the shared multiplier.
REQ-009 SHALL have port mul_result  in  XLEN  selected multiplier result.
REQ-010 SHALL have ports resp_valid out 1 / resp_ready in 1 / resp_data out XLEN / resp_rd out 5  writeback handshake.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE; drives the hazard-unit stall.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-013 SHALL drive req_ready = !flush && (state==IDLE || (state==RESP && resp_ready)).
REQ-014 SHALL, on accept (req_valid && req_ready) with req_funct3[2]==0, register funct3/a/b/rd and enter ISSUE.
REQ-015 SHALL assert mul_start for exactly the one ISSUE cycle, then enter WAIT with counter loaded to LATENCY-1.
REQ-016 SHALL hold mul_funct3/mul_a/mul_b stable from ISSUE until the result is captured.
REQ-017 SHALL, in WAIT, decrement the counter each edge; at counter==0, capture mul_result into resp_data and enter RESP.
REQ-018 SHALL therefore raise resp_valid LATENCY+1 edges after the accept edge (4 for LATENCY=3).
REQ-019 SHALL hold resp_valid, resp_data and resp_rd stable in RESP until resp_ready==1.
REQ-020 SHALL, on resp_ready in RESP, go to IDLE, or to ISSUE if a new request is accepted that same cycle (back-to-back, no bubble).
REQ-021 SHALL, on accept with req_funct3[2]==1 (divide ops, unsupported), skip the multiplier and enter RESP next edge with resp_data=0.
REQ-022 SHALL, on flush in ISSUE or WAIT, enter DRAIN; the counter keeps running, the result is discarded, and resp_valid stays 0.
REQ-023 SHALL leave DRAIN for IDLE when the counter reaches 0; req_ready stays 0 throughout DRAIN.
REQ-024 SHALL, on flush in RESP, deassert resp_valid next edge and enter IDLE, even if resp_ready is high that cycle.
REQ-025 SHALL ignore flush in IDLE and DRAIN.
REQ-026 SHALL never accept a request in a cycle where flush==1.

Reset
REQ-027 SHALL, while reset==0 at a clock edge, force state=IDLE, counter=0, mul_start=0, resp_valid=0, resp_data=0, resp_rd=0, mul_funct3=0, mul_a=0, mul_b=0; busy=0, and req_ready=1 after release.
REQ-028 SHALL treat reset asserted mid-operation like flush: the in-flight result is never reported after release.

Structure
REQ-029 SHALL take the FSM state enum and the funct3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011 from shared package mul_ctrl_pkg.
REQ-030 SHALL be a single flat module; no sub-module; it only connects to the multiplier and does not instantiate it.

Verification
REQ-031 SHALL cover MUL 7x6: accept at edge 0 -> mul_start high in cycle 1 -> resp_valid after edge 4 with resp_data=42 and resp_rd equal to the accepted tag.
REQ-032 SHALL cover MULH -2x3 with resp_ready held 0 for 5 cycles -> resp_valid and resp_data=0xFFFFFFFF stay stable, then complete on the first resp_ready.
REQ-033 SHALL cover a two-request sequence where resp_ready and the next req_valid coincide -> second accepted that cycle and mul_start in the next cycle.
REQ-034 SHALL cover flush in the first WAIT cycle -> no resp_valid, req_ready=0 until the counter expires, then IDLE.
REQ-035 SHALL cover funct3=100 -> no mul_start, and resp_valid the next cycle with resp_data=0.
REQ-036 SHALL cover reset=0 for one edge during WAIT -> all outputs at reset values, and no late resp_valid.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply issue controller.
//   state_e   : controller FSM states
//   F3_*      : RISC-V M-extension funct3 encodings handled by the multiplier
//               (funct3[2]==1 selects the divide group, which is not supported)
package mul_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // Divide-group opcodes bypass the multiplier and answer with zero.
    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// Issue controller between the EX stage and a shared fixed-latency multiplier.
// Accepts one operation, starts the multiplier, waits LATENCY edges, then
// presents the result on a valid/ready writeback port. A flush kills the
// operation; the counter keeps running in DRAIN so the multiplier pipeline
// empties before a new operation may be issued.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   req_valid/req_ready        EX-stage request handshake
//   req_funct3/a/b/rd          operation, operands, destination tag
//   flush                      kill in-flight or pending operation
//   mul_start/funct3/a/b       drive to the shared multiplier
//   mul_result                 multiplier result
//   resp_valid/ready/data/rd   writeback handshake
//   busy                       high whenever not IDLE (hazard stall)
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            mul_start,
    output logic [2:0]      mul_funct3,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] mul_result,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    // Counter only ever holds 0..LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            accept;

    assign req_ready  = !flush && (state_q == IDLE || (state_q == RESP && resp_ready));
    assign accept     = req_valid && req_ready;

    assign mul_start  = (state_q == ISSUE);
    assign mul_funct3 = f3_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = data_q;
    assign resp_rd    = rd_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        data_d  = data_q;

        case (state_q)
            IDLE: ;
            ISSUE: begin
                // The multiplier was started this cycle regardless of flush,
                // so a flushed op still has to drain the full latency.
                cnt_d   = CNT_LOAD;
                state_d = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_d = DRAIN;
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                end else if (cnt_q == '0) begin
                    data_d  = mul_result;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (flush || resp_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the RESP->IDLE exit so back-to-back ops have no bubble.
        if (accept) begin
            rd_d = req_rd;
            if (is_div(req_funct3)) begin
                data_d  = '0;
                state_d = RESP;
            end else begin
                f3_d    = req_funct3;
                a_d     = req_a;
                b_d     = req_b;
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= F3_MUL;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a
// transaction-level model (accept edge + fixed response delay).
module tb_mul_issue_ctrl;
    import mul_ctrl_pkg::*;

    localparam int LAT = 3;
    localparam int XL  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [2:0]    req_funct3;
    logic [XL-1:0] req_a, req_b;
    logic [4:0]    req_rd;
    logic          flush;
    logic          mul_start;
    logic [2:0]    mul_funct3;
    logic [XL-1:0] mul_a, mul_b, mul_result;
    logic          resp_valid, resp_ready;
    logic [XL-1:0] resp_data;
    logic [4:0]    resp_rd;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.LATENCY(LAT), .XLEN(XL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .flush(flush),
        .mul_start(mul_start), .mul_funct3(mul_funct3), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd),
        .busy(busy)
    );

    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            F3_MUL:    begin p = ua * ub; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            default:   return 32'h0;
        endcase
    endfunction

    // Multiplier stand-in: result is only correct once LAT edges have
    // passed since the start cycle; garbage before that.
    int age = 1000;
    always @(posedge clk) begin
        if (mul_start)       age <= 1;
        else if (age < 1000) age <= age + 1;
    end
    assign mul_result = (age >= LAT) ? ref_mul(mul_funct3, mul_a, mul_b)
                                     : (32'hBAD0_0000 ^ 32'(age));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: mode 0 idle, 1 multiply in flight, 2 responding,
    // 3 flushed multiply still draining. A multiply accepted at edge e
    // responds from edge e+LAT+1; a flushed one frees the unit at that edge.
    int          edge_n = 0;
    int          m_mode = 0;
    int          m_acc  = 0;
    int          m_due  = 0;
    logic [2:0]  m_f3   = '0;
    logic [31:0] m_a = '0, m_b = '0, m_data = '0;
    logic [4:0]  m_rd   = '0;

    always @(posedge clk) begin
        int e, mode, acc_e, due;
        logic [2:0]  f3;
        logic [31:0] a, b, d;
        logic [4:0]  rd;
        logic        acc;
        e = edge_n + 1;
        mode = m_mode; acc_e = m_acc; due = m_due;
        f3 = m_f3; a = m_a; b = m_b; d = m_data; rd = m_rd;
        if (!reset) begin
            mode = 0; f3 = '0; a = '0; b = '0; d = '0; rd = '0;
        end else begin
            acc = req_valid && !flush && (mode == 0 || (mode == 2 && resp_ready));
            case (mode)
                1: if (flush) begin
                       mode = 3;
                       if (e >= due) due = e + 1;
                   end else if (e == due) begin
                       mode = 2;
                       d = ref_mul(f3, a, b);
                   end
                2: if (flush || resp_ready) mode = 0;
                3: if (e >= due) mode = 0;
                default: ;
            endcase
            if (acc) begin
                rd = req_rd;
                if (req_funct3[2]) begin
                    mode = 2; d = '0;
                end else begin
                    mode = 1; f3 = req_funct3; a = req_a; b = req_b;
                    acc_e = e; due = e + LAT + 1;
                end
            end
        end
        edge_n <= e;
        m_mode <= mode; m_acc <= acc_e; m_due <= due;
        m_f3 <= f3; m_a <= a; m_b <= b; m_data <= d; m_rd <= rd;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("req_ready", 32'(req_ready), 32'(!flush && (m_mode == 0 || (m_mode == 2 && resp_ready))));
            chk("mul_start", 32'(mul_start), 32'(m_mode == 1 && edge_n == m_acc));
            chk("resp_valid", 32'(resp_valid), 32'(m_mode == 2));
            if (m_mode == 2) begin
                chk("resp_data", resp_data, m_data);
                chk("resp_rd", 32'(resp_rd), 32'(m_rd));
            end
            if (m_mode == 1) begin
                chk("mul_funct3", 32'(mul_funct3), 32'(m_f3));
                chk("mul_a", mul_a, m_a);
                chk("mul_b", mul_b, m_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b; req_rd = rd;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_a = '0; req_b = '0;
        req_rd = '0; flush = 1'b0; resp_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_mula", mul_a, 32'd0);
        reset = 1'b1;
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);

        // MUL 7x6
        drive_req(3'b000, 32'd7, 32'd6, 5'd9);
        step();
        req_valid = 1'b0;
        chk("t1_start", 32'(mul_start), 32'd1);
        step();
        chk("t1_start_once", 32'(mul_start), 32'd0);
        step(); step();
        chk("t1_early", 32'(resp_valid), 32'd0);
        step();
        chk("t1_valid", 32'(resp_valid), 32'd1);
        chk("t1_data", resp_data, 32'd42);
        chk("t1_rd", 32'(resp_rd), 32'd9);
        resp_ready = 1'b1; step(); resp_ready = 1'b0;

        // MULH -2x3 held by backpressure
        drive_req(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd5);
        step();
        req_valid = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(resp_valid), 32'd1);
            chk("t2_hold_data", resp_data, 32'hFFFF_FFFF);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t2_done", 32'(resp_valid), 32'd0);

        // back-to-back
        drive_req(3'b000, 32'd5, 32'd5, 5'd1);
        step();
        req_valid = 1'b0;
        repeat (4) step();
        chk("t3_first", resp_data, 32'd25);
        resp_ready = 1'b1;
        drive_req(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        step();
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("t3_b2b_start", 32'(mul_start), 32'd1);
        repeat (4) step();
        chk("t3_second", resp_data, 32'hFFFF_FFFE);
        chk("t3_rd", 32'(resp_rd), 32'd2);
        resp_ready = 1'b1; step(); resp_ready = 1'b0;

        // flush in first WAIT cycle
        drive_req(3'b000, 32'd3, 32'd3, 5'd4);
        step();
        req_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_drain_ready", 32'(req_ready), 32'd0);
        step();
        chk("t4_drain_ready2", 32'(req_ready), 32'd0);
        step();
        chk("t4_idle_ready", 32'(req_ready), 32'd1);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // divide opcode
        drive_req(3'b100, 32'd9, 32'd9, 5'd7);
        step();
        req_valid = 1'b0;
        chk("t5_nostart", 32'(mul_start), 32'd0);
        chk("t5_valid", 32'(resp_valid), 32'd1);
        chk("t5_data", resp_data, 32'd0);
        resp_ready = 1'b1; step(); resp_ready = 1'b0;

        // reset during WAIT
        drive_req(3'b000, 32'd11, 32'd13, 5'd3);
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rd", 32'(resp_rd), 32'd0);
        chk("t6_mulb", mul_b, 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t6_no_late", 32'(resp_valid), 32'd0);
            step();
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(99) != 0);
            flush      = ($urandom_range(15) == 0);
            req_valid  = ($urandom_range(1) == 1);
            req_funct3 = ($urandom_range(4) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
            req_a      = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom;
            req_b      = $urandom;
            req_rd     = 5'($urandom_range(31));
            resp_ready = ($urandom_range(9) < 6);
            step();
        end
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (8) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
